bip_tx_report: RTL and testbench
================================

# bip_tx_report

Result-reporting stage between the BIP processor and the UART transmitter in the top level. It counts clock cycles from reset until the processor halts. When the processor halts, it captures the accumulator, program counter and cycle count, then sends them as a fixed 7-byte frame to the UART TX through a start/done byte handshake. It issues one report per run and then parks until reset.

## Interface
- NB_INSTRUCTION, 16, accumulator width (data word of the processor)
- NB_ADDR, 11, program counter width
- NB_DATA, 8, UART byte width
- NB_CYCLE, 16, cycle counter width
- HEADER, 8'hA5, first byte of every frame

- i_clock  in  1  system clock, all logic on rising edge
- i_reset  in  1  asynchronous, active-low reset (all state cleared while low)
- i_halt  in  1  processor halted, level; stays high once asserted
- i_acc  in  NB_INSTRUCTION  processor accumulator
- i_pc  in  NB_ADDR  processor program counter
- i_tx_done  in  1  one-cycle pulse from UART TX: current byte finished
- o_tx_start  out  1  one-cycle pulse: UART TX loads o_tx_data
- o_tx_data  out  NB_DATA  byte to transmit, valid while o_tx_start high
- o_busy  out  1  frame transmission in progress
- o_done  out  1  frame fully sent; held until reset

## Operation
- Frame, byte order fixed: HEADER, acc[7:0], acc[15:8], pc[7:0], {5'b0, pc[10:8]}, cyc[7:0], cyc[15:8].
- The PC is zero-extended to 16 bits.
- Cycle counter: reset 0. It increments on each clock while in IDLE with i_halt low. It saturates at all-ones and never wraps.
- FSM states:
  - IDLE: on i_halt high, latch acc/pc/cycle count into a frame register, set byte index 0, go to SEND.
  - SEND: drive o_tx_start=1 with o_tx_data=byte[index] for exactly one cycle, go to WAIT.
  - WAIT: hold o_tx_data. On i_tx_done: if index==6 go to DONE, else index+1 and go to SEND.
  - DONE: terminal state. Holds until reset, and i_halt is ignored.
- i_tx_done outside WAIT is ignored. An i_tx_done that coincides with the SEND cycle is also ignored.
- i_acc/i_pc changes after capture do not affect the frame.
- o_busy = state in {SEND, WAIT}. o_done = state==DONE.
- Reset mid-frame (i_reset low): return to IDLE immediately, clear counter, frame register and index, and drop o_tx_start the same instant. The partial frame is abandoned and is not resumed.

## Timing
- Reset values: o_tx_start=0, o_tx_data=0, o_busy=0, o_done=0, counter=0, state IDLE.
- All outputs are registered.
- i_halt first sampled high at edge k: capture occurs at edge k. o_tx_start=1 and o_tx_data=HEADER during cycle k..k+1.
- The captured cycle count equals the number of edges after reset release before edge k. Halt high at the first edge gives 0.
- i_tx_done high at edge m: the next byte's o_tx_start is high during cycle m..m+1, with no extra gap.
- After the 7th i_tx_done at edge m: o_busy=0 and o_done=1 from edge m.
- o_tx_data changes only on the edge that raises o_tx_start.

## Structure
- A shared package holds:
  - HEADER
  - frame length (7)
  - state encoding (IDLE, SEND, WAIT, DONE)
  - byte index width ($clog2(7))
- The frame register is a 56-bit flat vector, indexed by byte.
- One sub-module, bip_cycle_counter: saturating counter with enable and asynchronous active-low clear.

## Test plan
- Reset, then i_halt high after 20 cycles with acc=16'h1234 and pc=11'h5AB. A UART model returns i_tx_done 10 cycles after each start. Required bytes: A5, 34, 12, AB, 05, 14, 00. o_done is high after the 7th done.
- Halt at the first edge after reset, acc=0, pc=0: frame is A5, 00, 00, 00, 00, 00, 00.
- Halt held low for 70000 cycles, then asserted: cycle bytes are FF, FF (saturation, no wrap).
- Spurious i_tx_done pulses in IDLE, in SEND and in DONE: no byte skipped, no extra start, exactly 7 o_tx_start pulses total.
- i_acc/i_pc toggling every cycle after capture: the frame still carries the captured values.
- i_reset low during the WAIT of byte 3: all outputs read 0 at once. After release and a new halt, the full 7-byte frame is resent starting with A5, and the counter restarts from 0.

Source files
------------

// File: rtl/bip_tx_report_pkg.sv
// Shared definitions for the BIP result-reporting stage: frame layout,
// FSM state encoding and a byte-select helper for the flat frame register.
package bip_tx_report_pkg;

  localparam logic [7:0] HEADER    = 8'hA5;
  localparam int         FRAME_LEN = 7;
  localparam int         BYTE_W    = 8;
  localparam int         FRAME_W   = FRAME_LEN * BYTE_W;
  localparam int         IDX_W     = $clog2(FRAME_LEN);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Byte 0 sits in the least significant byte of the flat frame.
  function automatic logic [BYTE_W-1:0] frame_byte(input logic [FRAME_W-1:0] frame,
                                                   input logic [IDX_W-1:0]   idx);
    return frame[{idx, 3'b000} +: BYTE_W];
  endfunction

endpackage

// File: rtl/bip_cycle_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear;
// it stops at all-ones instead of wrapping.
module bip_cycle_counter
  import bip_tx_report_pkg::*;
#(
  parameter int NB_CYCLE = 16
) (
  input  logic                i_clock,
  input  logic                i_clear_n,
  input  logic                i_enable,
  output logic [NB_CYCLE-1:0] o_count
);

  logic [NB_CYCLE-1:0] count_q;
  logic [NB_CYCLE-1:0] count_d;

  // Next count: hold at all-ones once reached.
  always_comb begin
    count_d = count_q;
    if (i_enable && (count_q != {NB_CYCLE{1'b1}})) begin
      count_d = count_q + {{(NB_CYCLE-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge i_clock or negedge i_clear_n) begin
    if (!i_clear_n) begin
      count_q <= {NB_CYCLE{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/bip_tx_report.sv
// Captures accumulator, PC and run length when the BIP processor halts and
// streams them to the UART TX as one fixed 7-byte frame per run.
module bip_tx_report
  import bip_tx_report_pkg::*;
#(
  parameter int NB_INSTRUCTION = 16,
  parameter int NB_ADDR        = 11,
  parameter int NB_DATA        = 8,
  parameter int NB_CYCLE       = 16
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_halt,
  input  logic [NB_INSTRUCTION-1:0] i_acc,
  input  logic [NB_ADDR-1:0]        i_pc,
  input  logic                      i_tx_done,
  output logic                      o_tx_start,
  output logic [NB_DATA-1:0]        o_tx_data,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int PC_PAD = NB_INSTRUCTION - NB_ADDR;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic                tx_start_q, tx_start_d;
  logic [NB_DATA-1:0]  tx_data_q, tx_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [NB_CYCLE-1:0] cycle_s;
  logic                count_en_s;

  assign count_en_s = (state_q == ST_IDLE) && !i_halt;

  bip_cycle_counter #(
    .NB_CYCLE (NB_CYCLE)
  ) u_cycle_counter (
    .i_clock   (i_clock),
    .i_clear_n (i_reset),
    .i_enable  (count_en_s),
    .o_count   (cycle_s)
  );

  // Next-state logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    case (state_q)
      ST_IDLE: begin
        if (i_halt) begin
          frame_d = {cycle_s, {PC_PAD{1'b0}}, i_pc, i_acc, HEADER};
          idx_d   = {IDX_W{1'b0}};
          state_d = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: state_d = ST_WAIT;
      ST_WAIT: begin
        if (!i_tx_done) begin
          state_d = ST_WAIT;
        end else if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
          state_d = ST_SEND;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase

    tx_start_d = (state_d == ST_SEND);
    busy_d     = (state_d == ST_SEND) || (state_d == ST_WAIT);
    done_d     = (state_d == ST_DONE);
    if (tx_start_d) begin
      tx_data_d = frame_byte(frame_d, idx_d);
    end else begin
      tx_data_d = tx_data_q;
    end
  end

  // State, frame and output registers; reset abandons any partial frame.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= {IDX_W{1'b0}};
      frame_q    <= {FRAME_W{1'b0}};
      tx_start_q <= 1'b0;
      tx_data_q  <= {NB_DATA{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_bip_tx_report.sv
// Directed bench for bip_tx_report: a frame-level reference model checked
// every cycle, plus literal frame expectations per scenario.
module tb_bip_tx_report;

  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_halt = 1'b0;
  logic [15:0] i_acc = 16'h0000;
  logic [10:0] i_pc = 11'h000;
  logic        i_tx_done = 1'b0;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        o_busy;
  logic        o_done;

  int n_tests = 0;
  int n_fail  = 0;

  bip_tx_report dut (
    .i_clock    (clk),
    .i_reset    (i_reset),
    .i_halt     (i_halt),
    .i_acc      (i_acc),
    .i_pc       (i_pc),
    .i_tx_done  (i_tx_done),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame bytes in transmission order, byte 0 in the top byte.
  int          edge_cnt  = 0;
  bit          m_captured = 1'b0;
  bit          m_finished = 1'b0;
  bit          m_start    = 1'b0;
  logic [7:0]  m_data     = 8'h00;
  int          m_sent     = 0;
  logic [55:0] m_frame    = 56'h0;
  logic [15:0] m_cyc;

  assign m_cyc = (edge_cnt > 65535) ? 16'hFFFF : edge_cnt[15:0];

  always @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      edge_cnt   <= 0;
      m_captured <= 1'b0;
      m_finished <= 1'b0;
      m_start    <= 1'b0;
      m_data     <= 8'h00;
      m_sent     <= 0;
      m_frame    <= 56'h0;
    end else begin
      edge_cnt <= edge_cnt + 1;
      if (!m_captured && i_halt) begin
        m_captured <= 1'b1;
        m_frame    <= {8'hA5, i_acc[7:0], i_acc[15:8], i_pc[7:0], {5'b00000, i_pc[10:8]},
                       m_cyc[7:0], m_cyc[15:8]};
        m_start    <= 1'b1;
        m_data     <= 8'hA5;
        m_sent     <= 1;
      end else if (m_start) begin
        m_start <= 1'b0;
      end else if (m_captured && !m_finished && i_tx_done) begin
        if (m_sent == 7) begin
          m_finished <= 1'b1;
        end else begin
          m_start <= 1'b1;
          m_data  <= m_frame[55 - 8*m_sent -: 8];
          m_sent  <= m_sent + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("tx_start", {31'd0, o_tx_start}, {31'd0, m_start});
    check("tx_data", {24'd0, o_tx_data}, {24'd0, m_data});
    check("busy", {31'd0, o_busy}, {31'd0, m_captured && !m_finished});
    check("done", {31'd0, o_done}, {31'd0, m_finished});
  end

  // Byte log of every start pulse since the last reset.
  logic [7:0] got[$];
  always @(negedge clk) begin
    if (!i_reset) got.delete();
    else if (o_tx_start) got.push_back(o_tx_data);
  end

  task automatic check_frame(input string tag, input logic [55:0] exp);
    check({tag, "_starts"}, got.size(), 32'd7);
    for (int i = 0; i < 7; i++) begin
      logic [7:0] a;
      a = (i < got.size()) ? got[i] : 8'h00;
      check($sformatf("%s_byte%0d", tag, i), {24'd0, a}, {24'd0, exp[55 - 8*i -: 8]});
    end
  endtask

  task automatic do_reset(input bit halt_at_release);
    i_reset   = 1'b0;
    i_halt    = halt_at_release;
    i_tx_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_start", {31'd0, o_tx_start}, 32'd0);
    check("rst_data", {24'd0, o_tx_data}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_done", {31'd0, o_done}, 32'd0);
    i_reset = 1'b1;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_tx_start) begin
        ok = 1'b1;
        return;
      end
    end
    check("start_timeout", 32'd0, 32'd1);
  endtask

  // UART stand-in: done pulse 10 cycles after each start; optional spurious done in SEND.
  task automatic serve(input bit spur, input int nbytes);
    bit ok;
    for (int b = 0; b < nbytes; b++) begin
      wait_start(ok);
      if (!ok) return;
      if (spur && (b == 2)) begin
        i_tx_done = 1'b1;
        @(posedge clk);
        #1 i_tx_done = 1'b0;
        repeat (8) @(posedge clk);
      end else begin
        repeat (9) @(posedge clk);
      end
      #1 i_tx_done = 1'b1;
      @(posedge clk);
      #1 i_tx_done = 1'b0;
    end
  endtask

  initial begin
    bit ok;

    // Halt after 20 cycles.
    i_acc = 16'h1234;
    i_pc  = 11'h5AB;
    do_reset(1'b0);
    repeat (20) @(posedge clk);
    #1 i_halt = 1'b1;
    serve(1'b0, 7);
    repeat (3) @(posedge clk);
    #1;
    check_frame("basic", 56'hA5_34_12_AB_05_14_00);
    check("basic_done", {31'd0, o_done}, 32'd1);

    // Halt already high at the first edge after reset.
    i_acc = 16'h0000;
    i_pc  = 11'h000;
    do_reset(1'b1);
    serve(1'b0, 7);
    repeat (3) @(posedge clk);
    #1;
    check_frame("first_edge", 56'hA5_00_00_00_00_00_00);

    // Counter saturation.
    i_acc = 16'hBEEF;
    i_pc  = 11'h7FF;
    do_reset(1'b0);
    repeat (70000) @(posedge clk);
    #1 i_halt = 1'b1;
    serve(1'b0, 7);
    repeat (3) @(posedge clk);
    #1;
    check_frame("saturate", 56'hA5_EF_BE_FF_07_FF_FF);

    // Spurious done in IDLE/SEND/DONE with inputs toggling after capture.
    i_acc = 16'hC3A5;
    i_pc  = 11'h2F0;
    do_reset(1'b0);
    i_tx_done = 1'b1;
    repeat (2) @(posedge clk);
    #1 i_tx_done = 1'b0;
    @(posedge clk);
    #1 i_halt = 1'b1;
    fork
      serve(1'b1, 7);
      begin
        repeat (60) begin
          @(posedge clk);
          #1;
          i_acc = ~i_acc;
          i_pc  = ~i_pc;
        end
      end
    join
    i_tx_done = 1'b1;
    repeat (3) @(posedge clk);
    #1 i_tx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_frame("spurious", 56'hA5_A5_C3_F0_02_03_00);
    check("spurious_done", {31'd0, o_done}, 32'd1);

    // Reset during WAIT of byte 3, then a full resend.
    i_acc = 16'h0F0F;
    i_pc  = 11'h100;
    do_reset(1'b0);
    repeat (7) @(posedge clk);
    #1 i_halt = 1'b1;
    serve(1'b0, 3);
    wait_start(ok);
    repeat (4) @(posedge clk);
    #1 i_reset = 1'b0;
    i_halt = 1'b0;
    #1;
    check("midrst_start", {31'd0, o_tx_start}, 32'd0);
    check("midrst_data", {24'd0, o_tx_data}, 32'd0);
    check("midrst_busy", {31'd0, o_busy}, 32'd0);
    check("midrst_done", {31'd0, o_done}, 32'd0);
    repeat (2) @(posedge clk);
    #1 i_reset = 1'b1;
    repeat (5) @(posedge clk);
    #1 i_halt = 1'b1;
    serve(1'b0, 7);
    repeat (3) @(posedge clk);
    #1;
    check_frame("resend", 56'hA5_0F_0F_00_01_05_00);
    check("resend_done", {31'd0, o_done}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
